hazard_ctrl: RTL and testbench

- Central stall generator for the 5-stage pipeline. Drives the shared `StallBus` consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers and by the ID→EX forwarding register.
- Detects load-use hazards, which cost a 1-cycle bubble into EX.
- Sequences multi-cycle mult/div occupancy of EX through a small FSM with a cycle counter.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall generator.
// Detects load-use hazards (one bubble into EX), sequences multi-cycle
// mult/div occupancy of EX with a small IDLE/BUSY/DONE FSM, and keeps a
// saturating count of cycles in which the PC was held.
module hazard_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic [4:0]  i_id_rs_raddr,
    input  logic [4:0]  i_id_rt_raddr,
    input  logic        i_id_rs_re,
    input  logic        i_id_rt_re,
    input  logic        i_ex_is_load,
    input  logic        i_ex_we,
    input  logic [4:0]  i_ex_waddr,
    input  logic        i_md_start,
    input  logic        i_md_is_div,
    output logic [5:0]  o_stall,
    output logic        o_md_busy,
    output logic        o_md_done,
    output logic [31:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Counter preload is occupancy minus one: BUSY lasts exactly N cycles.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_MD   = 6'b001111;
    localparam logic [5:0] STALL_LU   = 6'b000111;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] w_occ_nxt;
    logic             w_rs_hit;
    logic             w_rt_hit;
    logic             w_load_use;
    logic             w_md_stall;
    logic [5:0]       w_stall;
    logic [31:0]      r_stall_cnt;

    // Hazard detection and prioritised stall vector (flush > mult/div > load-use).
    always_comb begin
        w_rs_hit   = i_id_rs_re && (i_id_rs_raddr == i_ex_waddr);
        w_rt_hit   = i_id_rt_re && (i_id_rt_raddr == i_ex_waddr);
        w_load_use = i_ex_is_load && i_ex_we && (i_ex_waddr != 5'd0)
                     && (w_rs_hit || w_rt_hit);
        w_md_stall = ((r_state == S_IDLE) && i_md_start) || (r_state == S_BUSY);
        if (i_flush) begin
            w_stall = STALL_NONE;
        end else if (w_md_stall) begin
            w_stall = STALL_MD;
        end else if (w_load_use) begin
            w_stall = STALL_LU;
        end else begin
            w_stall = STALL_NONE;
        end
    end

    // Mult/div occupancy FSM next-state and counter update.
    always_comb begin
        w_state_nxt = r_state;
        w_occ_nxt   = r_occ;
        if (i_flush) begin
            w_state_nxt = S_IDLE;
            w_occ_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_md_start) begin
                        w_state_nxt = S_BUSY;
                        w_occ_nxt   = i_md_is_div ? DIV_LOAD : MUL_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (r_occ != '0) begin
                        w_occ_nxt = r_occ - 1'b1;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    // The mult/div instruction leaves EX this cycle; md_start is stale.
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_occ_nxt   = '0;
                end
            endcase
        end
    end

    // FSM state and occupancy counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_occ   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_occ   <= w_occ_nxt;
        end
    end

    // Saturating count of cycles with the PC held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall[0] && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign o_stall     = w_stall;
    assign o_md_busy   = (r_state == S_BUSY);
    assign o_md_done   = (r_state == S_DONE);
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (default parameters).
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [4:0]  id_rs_raddr;
    logic [4:0]  id_rt_raddr;
    logic        id_rs_re;
    logic        id_rt_re;
    logic        ex_is_load;
    logic        ex_we;
    logic [4:0]  ex_waddr;
    logic        md_start;
    logic        md_is_div;
    logic [5:0]  stall;
    logic        md_busy;
    logic        md_done;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    hazard_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .i_flush       (flush),
        .i_id_rs_raddr (id_rs_raddr),
        .i_id_rt_raddr (id_rt_raddr),
        .i_id_rs_re    (id_rs_re),
        .i_id_rt_re    (id_rt_re),
        .i_ex_is_load  (ex_is_load),
        .i_ex_we       (ex_we),
        .i_ex_waddr    (ex_waddr),
        .i_md_start    (md_start),
        .i_md_is_div   (md_is_div),
        .o_stall       (stall),
        .o_md_busy     (md_busy),
        .o_md_done     (md_done),
        .o_stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_md(input string tag, input logic [5:0] e_stall,
                          input logic e_busy, input logic e_done);
        chk({tag, ".stall"}, {26'd0, stall}, {26'd0, e_stall});
        chk({tag, ".busy"},  {31'd0, md_busy}, {31'd0, e_busy});
        chk({tag, ".done"},  {31'd0, md_done}, {31'd0, e_done});
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic clr_hazard();
        id_rs_raddr = 5'd0; id_rt_raddr = 5'd0;
        id_rs_re = 1'b0; id_rt_re = 1'b0;
        ex_is_load = 1'b0; ex_we = 1'b0; ex_waddr = 5'd0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; md_start = 1'b0; md_is_div = 1'b0;
        clr_hazard();
        nxt(); nxt();
        #1;
        chk_md("reset", 6'b000000, 1'b0, 1'b0);
        chk("reset.cnt", stall_cnt, 32'd0);
        rst = 1'b0;

        // Load-use on rs -> one-cycle bubble (counted)
        nxt();
        ex_is_load = 1'b1; ex_we = 1'b1; ex_waddr = 5'd5;
        id_rs_raddr = 5'd5; id_rs_re = 1'b1;
        #1; chk("lu_rs", {26'd0, stall}, {26'd0, 6'b000111});
        // Register $0 never hazards
        nxt();
        ex_waddr = 5'd0; id_rs_raddr = 5'd0;
        #1; chk("lu_r0", {26'd0, stall}, 32'd0);
        // rt-only hazard, rs address matches but is not read (counted)
        nxt();
        ex_waddr = 5'd9; id_rs_raddr = 5'd9; id_rs_re = 1'b0;
        id_rt_raddr = 5'd9; id_rt_re = 1'b1;
        #1; chk("lu_rt", {26'd0, stall}, {26'd0, 6'b000111});
        nxt();
        id_rt_re = 1'b0;
        #1; chk("lu_rt_off", {26'd0, stall}, 32'd0);
        // Not a load / no write-back -> no hazard
        nxt();
        id_rs_re = 1'b1; ex_we = 1'b0;
        #1; chk("lu_nowe", {26'd0, stall}, 32'd0);
        nxt();
        ex_we = 1'b1; ex_is_load = 1'b0;
        #1; chk("lu_noload", {26'd0, stall}, 32'd0);
        nxt();
        clr_hazard();
        #1; chk("cnt_after_lu", stall_cnt, 32'd2);

        // Multiply, with an (illegal) load-use present at t0: md wins
        nxt();
        md_start = 1'b1; md_is_div = 1'b0;
        ex_is_load = 1'b1; ex_we = 1'b1; ex_waddr = 5'd3;
        id_rs_raddr = 5'd3; id_rs_re = 1'b1;
        #1; chk_md("mul_t0", 6'b001111, 1'b0, 1'b0);
        nxt(); clr_hazard();
        #1; chk_md("mul_t1", 6'b001111, 1'b1, 1'b0);
        nxt();
        #1; chk_md("mul_t2", 6'b001111, 1'b1, 1'b0);
        nxt();
        #1; chk_md("mul_t3", 6'b000000, 1'b0, 1'b1);
        md_start = 1'b0;
        nxt();
        #1; chk_md("mul_t4", 6'b000000, 1'b0, 1'b0);
        chk("mul_cnt", stall_cnt, 32'd5);

        // Divide: 34 stalled cycles, md_is_div not resampled mid-operation
        nxt();
        md_start = 1'b1; md_is_div = 1'b1;
        #1; chk_md("div_t0", 6'b001111, 1'b0, 1'b0);
        for (int k = 1; k <= 33; k++) begin
            nxt();
            if (k == 5) md_is_div = 1'b0;
            #1; chk_md($sformatf("div_t%0d", k), 6'b001111, 1'b1, 1'b0);
        end
        nxt();
        #1; chk_md("div_t34", 6'b000000, 1'b0, 1'b1);
        md_start = 1'b0;
        nxt();
        #1; chk_md("div_t35", 6'b000000, 1'b0, 1'b0);
        chk("div_cnt", stall_cnt, 32'd39);

        // Flush at BUSY cycle 10 of a divide
        nxt();
        md_start = 1'b1; md_is_div = 1'b1;
        #1; chk_md("fl_t0", 6'b001111, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            nxt();
        end
        nxt();
        flush = 1'b1;
        #1; chk_md("fl_t10", 6'b000000, 1'b1, 1'b0);
        nxt();
        flush = 1'b0; md_start = 1'b0;
        #1; chk_md("fl_t11", 6'b000000, 1'b0, 1'b0);
        nxt();
        #1; chk_md("fl_t12", 6'b000000, 1'b0, 1'b0);
        chk("fl_cnt", stall_cnt, 32'd49);
        // Flush beats md_start in IDLE
        nxt();
        flush = 1'b1; md_start = 1'b1; md_is_div = 1'b0;
        #1; chk_md("fl_idle", 6'b000000, 1'b0, 1'b0);
        nxt();
        flush = 1'b0; md_start = 1'b0;
        #1; chk_md("fl_idle_nx", 6'b000000, 1'b0, 1'b0);
        // Restart after flush uses the full divide count
        nxt();
        md_start = 1'b1; md_is_div = 1'b1;
        #1; chk_md("rs_t0", 6'b001111, 1'b0, 1'b0);
        for (int k = 1; k <= 33; k++) begin
            nxt();
            #1; chk_md($sformatf("rs_t%0d", k), 6'b001111, 1'b1, 1'b0);
        end
        nxt();
        #1; chk_md("rs_t34", 6'b000000, 1'b0, 1'b1);
        md_start = 1'b0;
        nxt();
        #1; chk("rs_cnt", stall_cnt, 32'd83);

        // Reset while BUSY (counter at 17)
        md_start = 1'b1; md_is_div = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            nxt();
        end
        #1; chk_md("rb_t16", 6'b001111, 1'b1, 1'b0);
        rst = 1'b1;
        nxt();
        rst = 1'b0; md_start = 1'b0;
        #1; chk_md("rb_after", 6'b000000, 1'b0, 1'b0);
        chk("rb_cnt", stall_cnt, 32'd0);

        // Saturation of the stall counter
        nxt();
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        #1; chk("sat_pre", stall_cnt, 32'hFFFF_FFFE);
        ex_is_load = 1'b1; ex_we = 1'b1; ex_waddr = 5'd7;
        id_rt_raddr = 5'd7; id_rt_re = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            nxt();
            #1; chk($sformatf("sat_%0d", k), stall_cnt, 32'hFFFF_FFFF);
        end
        clr_hazard();
        nxt();
        #1; chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
